// File: rtl/ripple_count_sampler.sv
// Synchronises and de-glitches a 4-bit ripple counter, extends it with a wrap epoch,
// and serves snapshots over valid/ready. RIPPLE_SAMPLER_QBAR_EN selects a Q_bar input.
module ripple_count_sampler #(
    parameter int CNT_W         = 4,
    parameter int EPOCH_W       = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         q_in,
    input  logic                     sample_req,
    input  logic                     sample_ready,
    output logic                     sample_valid,
    output logic [EPOCH_W+CNT_W-1:0] sample_data,
    output logic                     stable,
    output logic                     wrap_pulse
);

    localparam logic [3:0] LP_SC = 4'(STABLE_CYCLES);

`ifdef RIPPLE_SAMPLER_QBAR_EN
    localparam logic [CNT_W-1:0] LP_SYNC_RST = '1;
`else
    localparam logic [CNT_W-1:0] LP_SYNC_RST = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    logic [CNT_W-1:0]         r_sync1;
    logic [CNT_W-1:0]         r_sync2;
    logic [CNT_W-1:0]         r_cand;
    logic [3:0]               r_cnt;
    logic [CNT_W-1:0]         r_stable_val;
    logic [EPOCH_W-1:0]       r_epoch;
    logic                     r_wrap;
    logic                     r_valid;
    logic [EPOCH_W+CNT_W-1:0] r_data;
    state_t                   r_state;
    state_t                   w_next;
    logic                     w_capture;
    logic                     w_release;
    logic [CNT_W-1:0]         w_dec;
    logic [3:0]               w_cnt_inc;

`ifdef RIPPLE_SAMPLER_QBAR_EN
    assign w_dec = ~r_sync2;
`else
    assign w_dec = r_sync2;
`endif

    assign w_cnt_inc = r_cnt + 4'd1;
    assign stable    = (r_cnt == LP_SC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= LP_SYNC_RST;
            r_sync2 <= LP_SYNC_RST;
        end else begin
            r_sync1 <= q_in;
            r_sync2 <= r_sync1;
        end
    end

    // A value is accepted only once it has been seen STABLE_CYCLES+1 times in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand       <= '0;
            r_cnt        <= '0;
            r_stable_val <= '0;
            r_epoch      <= '0;
            r_wrap       <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_dec != r_cand) begin
                r_cand <= w_dec;
                r_cnt  <= '0;
            end else if (r_cnt < LP_SC) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == LP_SC) begin
                    r_stable_val <= r_cand;
                    if (r_cand < r_stable_val) begin
                        r_epoch <= r_epoch + EPOCH_W'(1);
                        r_wrap  <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (sample_req) begin
                    if (stable) begin
                        w_capture = 1'b1;
                        w_next    = S_HOLD;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (stable) begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (sample_ready) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_valid <= 1'b1;
                r_data  <= {r_epoch, r_stable_val};
            end else if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_valid = r_valid;
    assign sample_data  = r_data;
    assign wrap_pulse   = r_wrap;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler: vector table, directed corner sequences and
// randomized input runs checked against a run-length reference model.
module tb_ripple_count_sampler;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  q_in = 4'h0;
    logic        sample_req = 1'b0;
    logic        sample_ready = 1'b0;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        stable;
    logic        wrap_pulse;

    ripple_count_sampler #(
        .CNT_W(4),
        .EPOCH_W(8),
        .STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .q_in(q_in),
        .sample_req(sample_req),
        .sample_ready(sample_ready),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .stable(stable),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_wrap = 0;

    // Reference model: logical counter value as driven, seen 2 edges late
    logic [3:0]  v_drive = 4'h0;
    logic [3:0]  hist[$];
    int          run = 1;
    logic [3:0]  m_cur = 4'h0;
    logic [3:0]  m_val = 4'h0;
    logic [7:0]  m_epoch = 8'h00;
    logic        m_wrap = 1'b0;
    logic        m_stable = 1'b0;
    logic [11:0] m_pre = 12'h000;

    always @(posedge clk) begin : model
        logic [3:0] s;
        if (reset) begin
            hist     = {4'h0, 4'h0};
            run      = 1;
            m_cur    = 4'h0;
            m_val    = 4'h0;
            m_epoch  = 8'h00;
            m_wrap   = 1'b0;
            m_stable = 1'b0;
            m_pre    = 12'h000;
        end else begin
            m_pre  = {m_epoch, m_val};
            s      = hist.pop_front();
            hist.push_back(v_drive);
            m_wrap = 1'b0;
            if (s != m_cur) begin
                m_cur = s;
                run   = 1;
            end else if (run <= S) begin
                run = run + 1;
                if (run == S + 1) begin
                    if (s < m_val) begin
                        m_wrap  = 1'b1;
                        m_epoch = m_epoch + 8'd1;
                    end
                    m_val = s;
                end
            end
            m_stable = (run == S + 1);
        end
    end

    function automatic logic [3:0] enc(input logic [3:0] v);
`ifdef RIPPLE_SAMPLER_QBAR_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (wrap_pulse) n_wrap++;
        chk("stable_model", {31'd0, stable}, {31'd0, m_stable});
        chk("wrap_model", {31'd0, wrap_pulse}, {31'd0, m_wrap});
    endtask

    task automatic set_v(input logic [3:0] v);
        v_drive = v;
        q_in    = enc(v);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        set_v(v);
        repeat (n) step();
    endtask

    task automatic do_reset(input logic [3:0] v);
        set_v(v);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic snap(input logic use_model, input logic [11:0] exp, input int hold_cyc);
        logic        found;
        logic [11:0] expv;
        found = 1'b0;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (sample_valid) found = 1'b1;
            else step();
        end
        chk("snap_timeout", {31'd0, found}, 32'd1);
        if (found) begin
            expv = use_model ? m_pre : exp;
            chk("snap_data", {20'd0, sample_data}, {20'd0, expv});
            for (int i = 0; i < hold_cyc; i++) begin
                step();
                chk("hold_valid", {31'd0, sample_valid}, 32'd1);
                chk("hold_data", {20'd0, sample_data}, {20'd0, expv});
            end
            sample_ready = 1'b1;
            step();
            sample_ready = 1'b0;
            chk("snap_release", {31'd0, sample_valid}, 32'd0);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        req;
        logic        rdy;
        logic        e_stable;
        logic        e_valid;
        logic        cd;
        logic [11:0] e_data;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic seen;
        tbl[0]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[1]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[2]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[3]  = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[4]  = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[5]  = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[6]  = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[7]  = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[8]  = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h005};
        tbl[9]  = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h005};
        tbl[10] = '{1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};

        for (int i = 0; i < 11; i++) begin
            reset        = tbl[i].rst;
            set_v(tbl[i].v);
            sample_req   = tbl[i].req;
            sample_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_stable", i), {31'd0, stable}, {31'd0, tbl[i].e_stable});
            chk($sformatf("tbl%0d_valid", i), {31'd0, sample_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_wrap", i), {31'd0, wrap_pulse}, 32'd0);
            if (tbl[i].cd)
                chk($sformatf("tbl%0d_data", i), {20'd0, sample_data}, {20'd0, tbl[i].e_data});
        end
        sample_req   = 1'b0;
        sample_ready = 1'b0;

        // glitch rejection: 6 and 4 last one sample each
        hold(4'h7, 8);
        snap(1'b0, 12'h007, 0);
        w0 = n_wrap;
        hold(4'h6, 1);
        hold(4'h4, 1);
        hold(4'h8, 8);
        chk("glitch_wrap", n_wrap - w0, 32'd0);
        snap(1'b0, 12'h008, 0);

        // wrap and epoch rollover
        do_reset(4'h0);
        w0 = n_wrap;
        for (int v = 0; v < 16; v++) hold(4'(v), 8);
        hold(4'h0, 8);
        chk("wrap_once", n_wrap - w0, 32'd1);
        snap(1'b0, 12'h010, 0);
        for (int i = 1; i < 256; i++) begin
            hold(4'hF, 5);
            hold(4'h0, 5);
        end
        chk("wrap_total", n_wrap - w0, 32'd256);
        snap(1'b0, 12'h000, 0);

        // handshake hold with epoch 3, second request ignored
        do_reset(4'h0);
        for (int i = 0; i < 3; i++) begin
            hold(4'hF, 5);
            hold(4'h0, 5);
        end
        hold(4'h9, 8);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        chk("hs_valid_rise", {31'd0, sample_valid}, 32'd1);
        chk("hs_data", {20'd0, sample_data}, 32'h039);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                sample_req = 1'b1;
                set_v(4'hA);
            end
            step();
            sample_req = 1'b0;
            chk("hs_hold_valid", {31'd0, sample_valid}, 32'd1);
            chk("hs_hold_data", {20'd0, sample_data}, 32'h039);
        end
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        chk("hs_release", {31'd0, sample_valid}, 32'd0);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        chk("hs_next_valid", {31'd0, sample_valid}, 32'd1);
        chk("hs_next_data", {20'd0, sample_data}, 32'h03A);

        // reset in HOLD drops valid without a clock edge
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_async_data", {20'd0, sample_data}, 32'd0);
        set_v(4'h2);
        repeat (2) step();
        reset = 1'b0;

        // request while the filter is unsettled
        hold(4'h2, 8);
        set_v(4'h3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (!stable) seen = 1'b1;
        end
        chk("ws_unstable", {31'd0, seen}, 32'd1);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (stable) begin
                seen = 1'b1;
            end else begin
                chk("ws_early_valid", {31'd0, sample_valid}, 32'd0);
                step();
            end
        end
        chk("ws_stable_seen", {31'd0, seen}, 32'd1);
        chk("ws_valid_lag", {31'd0, sample_valid}, 32'd0);
        step();
        chk("ws_valid", {31'd0, sample_valid}, 32'd1);
        chk("ws_data", {20'd0, sample_data}, 32'h003);
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;

        // complemented-input build decodes back to A
        hold(4'hA, 8);
        snap(1'b0, 12'h00A, 2);

        // randomized ripple activity
        for (int seg = 0; seg < 200; seg++) begin
            logic [3:0] rv;
            rv = 4'($urandom_range(0, 15));
            hold(rv, $urandom_range(1, 5));
            if (seg % 25 == 24) begin
                hold(rv, 6);
                snap(1'b1, 12'h000, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ripple_count_sampler.md
# ripple_count_sampler

Synchronous capture stage that sits directly downstream of the 4-bit asynchronous (ripple) binary counter. It synchronises the counter's ripple outputs into the `clk` domain and filters out transient ripple states. It extends the count with a wrap (epoch) counter and delivers on-demand snapshots through a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 4: width of the ripple counter value.
- `EPOCH_W`, default 8: width of the wrap counter.
- `STABLE_CYCLES`, default 2: consecutive equal synchronised samples required before a value is accepted. Legal range is 1..15.

Ports:
- `clk` in 1: sampling clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `q_in` in CNT_W: raw ripple counter output; asynchronous to `clk`.
- `sample_req` in 1: one-cycle request for a snapshot.
- `sample_ready` in 1: consumer accepts `sample_data`.
- `sample_valid` out 1: snapshot held on `sample_data`.
- `sample_data` out EPOCH_W+CNT_W: snapshot, `{epoch, stable_val}`.
- `stable` out 1: filter counter saturated; the current value is settled.
- `wrap_pulse` out 1: one-cycle pulse when an accepted value wraps.

## Operation
- **Synchroniser:** `q_in` passes through `sync1` and then `sync2`, both CNT_W wide. Nothing downstream reads `sync1`.
- **Glitch filter:** registers `cand` (CNT_W) and `cnt` (4 bits).
  - If `sync2 != cand`: load `cand <= sync2` and set `cnt <= 0`.
  - Otherwise, while `cnt < STABLE_CYCLES`: increment `cnt`.
  - On the increment that reaches `STABLE_CYCLES`: `stable_val <= cand`.
- **Stable output:** `stable = (cnt == STABLE_CYCLES)`. This is combinational from the register.
- **Wrap detect:** on every acceptance where the new value is less than the old `stable_val`:
  - `wrap_pulse <= 1` for exactly one cycle.
  - `epoch <= epoch + 1`, modulo 2^EPOCH_W. At all-ones it silently wraps to 0.
  - An acceptance of an equal or larger value does not wrap.
- **Snapshot FSM**, states IDLE, WAIT_STABLE, HOLD:
  - IDLE, `sample_req` and `stable`: capture `{epoch, stable_val}` (register values before this edge's update), set `sample_valid`, go to HOLD.
  - IDLE, `sample_req` and not `stable`: go to WAIT_STABLE.
  - WAIT_STABLE, `stable`: capture, go to HOLD. `sample_req` is ignored here.
  - HOLD: `sample_valid = 1` and `sample_data` stay frozen. On `sample_ready`: clear `sample_valid`, go to IDLE. `sample_req` is ignored in HOLD.
- **Reset values:** all of the following are 0, and the FSM is in IDLE:
  - `sync1`, `sync2`, `cand`, `stable_val`, `epoch`, `cnt`
  - `sample_valid`, `sample_data`, `wrap_pulse`
- **Reset mid-handshake:** aborts immediately. `sample_valid` drops asynchronously and the snapshot is lost.

## Timing
- **`q_in` to `stable_val`:** with `q_in` settled before edge 0:
  - `sync1` updates at edge 0, `sync2` at edge 1, `cand` at edge 2.
  - `stable_val` updates at edge 2+STABLE_CYCLES, i.e. edge 4 by default.
- **`wrap_pulse`:** high for the single cycle following the edge that updates `stable_val`.
- **Ripple transient:** a transient lasting fewer than STABLE_CYCLES+1 synchronised samples is never accepted.
- **Request to valid:**
  - IDLE with `stable`: `sample_valid` rises 1 cycle after the `sample_req` edge.
  - Otherwise: 1 cycle after `stable` is first seen high in WAIT_STABLE.
- **Handshake:** the transfer completes on the edge where `sample_valid` and `sample_ready` are both high. The earliest next `sample_valid` comes 2 edges later (IDLE, then capture).
- **Simultaneous acceptance and capture:** the snapshot takes the pre-update `stable_val` and `epoch`.

## Configuration
- **`RIPPLE_SAMPLER_QBAR_EN` defined:** `q_in` is the counter's complemented output (`Q_bar`).
  - `sync2` is inverted before the filter: `cand` compares against `~sync2`.
  - The reset value of `sync1`/`sync2` is all-ones, so the decoded value at reset is 0.
- **Undefined:** `q_in` is the true `Q` output, used without inversion; reset value 0.

## Test plan
- **Reset:** assert `reset` for 3 cycles with `q_in=4'h5`.
  - All outputs read 0 during reset.
  - After release, `stable_val` reaches 5 at edge 4 and `stable` rises.
- **Glitch rejection:** step `q_in` 4'h7 -> 4'h6 (1 cycle) -> 4'h4 (1 cycle) -> 4'h8, held.
  - `stable_val` goes directly from 7 to 8, with no 6 or 4 ever accepted.
  - `wrap_pulse` stays 0.
- **Wrap:** count `q_in` 0..15 then 0, each value held 8 cycles.
  - Exactly one `wrap_pulse`, and `epoch=1`.
  - Repeating to 256 wraps gives `epoch=0`.
- **Handshake:** with the input stable at 9 and `epoch=3`, pulse `sample_req` and hold `sample_ready=0` for 5 cycles.
  - `sample_valid` stays 1 with `sample_data=12'h039`; a second `sample_req` is ignored.
  - `sample_ready=1` clears `sample_valid` on that edge.
- **WAIT_STABLE:** pulse `sample_req` 1 cycle after `q_in` changes 2 -> 3.
  - `sample_valid` rises only after `stable` rises, with data `{epoch,4'h3}`.
- **Macro on:** drive `q_in=~4'hA`.
  - `stable_val=4'hA`, and the snapshot data ends in A.
